// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet source: one packet of len_bytes per start pulse, counter or LFSR payload.
// Define AXIS_PKT_GEN_LFSR_EN to replace the incrementing payload with a 32-bit Galois LFSR.
module axis_pkt_gen #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             start,
    input  logic [LEN_W-1:0] len_bytes,
    input  logic [31:0]      seed,
    output logic [31:0]      m_axis_tdata,
    output logic [3:0]       m_axis_tkeep,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             busy,
    output logic             done,
    output logic [31:0]      pkt_cnt
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    logic [LEN_W-2:0] beats_left;
    logic [1:0]       tail;
    logic [LEN_W:0]   len_round;
    logic [LEN_W-2:0] beats_req;
    logic [31:0]      first_data;
    logic             accept;

    // ceil(len/4) of a LEN_W-bit length always fits in LEN_W-1 bits
    assign len_round = {1'b0, len_bytes} + (LEN_W+1)'(3);
    assign beats_req = (LEN_W-1)'(len_round >> 2);
    assign accept    = m_axis_tvalid && m_axis_tready;

    function automatic logic [3:0] keep_for(input logic [1:0] t);
        logic [3:0] k;
        case (t)
            2'd1:    k = 4'h1;
            2'd2:    k = 4'h3;
            2'd3:    k = 4'h7;
            default: k = 4'hF;
        endcase
        return k;
    endfunction

`ifdef AXIS_PKT_GEN_LFSR_EN
    function automatic logic [31:0] next_data(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    // An all-zero LFSR state would lock up, so a zero seed starts at 1
    assign first_data = (seed == 32'h0) ? 32'h0000_0001 : seed;
`else
    function automatic logic [31:0] next_data(input logic [31:0] x);
        return x + 32'd1;
    endfunction

    assign first_data = seed;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            beats_left    <= '0;
            tail          <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pkt_cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (len_bytes != '0)) begin
                        state         <= SEND;
                        m_axis_tvalid <= 1'b1;
                        busy          <= 1'b1;
                        m_axis_tdata  <= first_data;
                        beats_left    <= beats_req;
                        tail          <= len_bytes[1:0];
                        if (beats_req == (LEN_W-1)'(1)) begin
                            m_axis_tlast <= 1'b1;
                            m_axis_tkeep <= keep_for(len_bytes[1:0]);
                        end else begin
                            m_axis_tlast <= 1'b0;
                            m_axis_tkeep <= 4'hF;
                        end
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (m_axis_tlast) begin
                            state         <= IDLE;
                            m_axis_tvalid <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            pkt_cnt       <= pkt_cnt + 32'd1;
                        end else begin
                            // beats_left counts the beat being presented; 2 means the next is last
                            beats_left   <= beats_left - (LEN_W-1)'(1);
                            m_axis_tdata <= next_data(m_axis_tdata);
                            if (beats_left == (LEN_W-1)'(2)) begin
                                m_axis_tlast <= 1'b1;
                                m_axis_tkeep <= keep_for(tail);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
